limber_gnrl_ramfifo_ctrl: RTL and testbench
===========================================

LIMBER_GNRL_RAMFIFO_CTRL -- requirements
Module: limber_gnrl_ramfifo_ctrl

Interface
REQ-001 SHALL have parameter DP, default 4: RAM depth in entries, power of 2, >=2.
REQ-002 SHALL have parameter AW, default 2: RAM address width, equal to log2(DP).
REQ-003 SHALL have parameter DW, default 3: data width.
REQ-004 SHALL have parameter DLY, default 1: RAM read latency in clocks, >=1.
REQ-005 SHALL have port clk, input, 1: single clock; all state on rising edge.
REQ-006 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have port i_vld, input, 1: write-side data valid.
REQ-008 SHALL have port i_rdy, output, 1: write-side ready.
REQ-009 SHALL have port i_dat, input, DW: write-side data.
REQ-010 SHALL have port o_vld, output, 1: read-side data valid.
REQ-011 SHALL have port o_rdy, input, 1: read-side ready.
REQ-012 SHALL have port o_dat, output, DW: read-side data.
REQ-013 SHALL have ports ram_cs, ram_we (output, 1), ram_waddr, ram_raddr (output, AW) and ram_din (output, DW): RAM control and write data.
REQ-014 SHALL have port ram_dout, input, DW: RAM read data, valid DLY clocks after the read-issue cycle.
REQ-015 SHALL have port usedw, output, AW+1: count of entries held in RAM, not yet read-issued.

Function
REQ-016 SHALL define push = i_vld & i_rdy, with i_rdy = (usedw < DP), independent of i_vld.
REQ-017 SHALL, on push, drive ram_we=1, ram_waddr=wptr and ram_din=i_dat combinationally, and increment wptr modulo DP at the clock edge.
REQ-018 SHALL define issue = (usedw != 0) & (credit != 0), where credit = (DLY+1) - (entries in flight + entries in output queue).
REQ-019 SHALL, on issue, drive ram_raddr=rptr and increment rptr modulo DP at the clock edge.
REQ-020 SHALL hold ram_raddr at rptr whenever issue=0.
REQ-021 SHALL drive ram_cs = push | issue, and ram_we = push.
REQ-022 SHALL update usedw each edge by +push -issue, so a simultaneous push and issue leaves it unchanged.
REQ-023 SHALL never issue a read to an entry written in the same cycle, because usedw counts only entries committed at previous edges.
REQ-024 SHALL track issued reads in a DLY-stage valid shift pipe, and capture ram_dout into the output queue when the last stage is valid.
REQ-025 SHALL implement the output queue as a DLY+1-entry FIFO with in-order delivery, so returning data can never overflow it.
REQ-026 SHALL drive o_vld = output queue non-empty and o_dat = queue head; the head pops when o_vld & o_rdy.
REQ-027 SHALL allow a capture and a pop in the same cycle on the output queue, including when the queue is full.
REQ-028 SHALL sustain one push per clock and, with o_rdy held 1, one o_vld & o_rdy transfer per clock.
REQ-029 SHALL have an empty-to-output latency of DLY+1 clocks: a push at edge N gives o_vld=1 after edge N+DLY+1.
REQ-030 SHALL keep o_dat stable while o_vld=1 & o_rdy=0.
REQ-031 SHALL handle pointer wrap-around naturally, with full/empty taken from usedw and not from pointer comparison.

Reset
REQ-032 SHALL, on rst_n low, clear wptr, rptr, usedw, the in-flight pipe and the output queue to 0 asynchronously; RAM contents are not cleared.
REQ-033 SHALL, during reset, hold outputs at i_rdy=1, o_vld=0, ram_cs=0, ram_we=0, usedw=0, ram_raddr=0, ram_waddr=0.
REQ-034 SHALL discard in-flight reads and queued data on reset mid-operation; data returned after reset release is ignored.

Verification
REQ-035 SHALL verify single entry (DP=4, DLY=1, DW=8): push 0xA5 at edge 0 with o_rdy=1 -> issue at cycle 1, o_vld=1 with o_dat=0xA5 after edge 2, then o_vld=0.
REQ-036 SHALL verify fill to full: o_rdy=0, push 0x01..0x08 -> output queue takes 0x01,0x02; usedw reaches 4; i_rdy=0 after the 6th push; the 7th and 8th are stalled, not lost.
REQ-037 SHALL verify drain and wrap: after the full case, set o_rdy=1 -> o_dat sequence 0x01..0x06 in order; pointers wrap to 2; then push 0x07,0x08 -> delivered in order.
REQ-038 SHALL verify streaming: i_vld=1 and o_rdy=1 for 20 cycles with an incrementing pattern -> one output per clock after a 2-clock fill, usedw <= 1, no gaps.
REQ-039 SHALL verify backpressure toggling: o_rdy alternating 1/0 with continuous pushes -> no data loss or duplication, and o_dat stable while stalled.
REQ-040 SHALL verify reset mid-stream: assert rst_n=0 with usedw=3 and o_vld=1 -> o_vld=0, usedw=0 and i_rdy=1 immediately; after release, the first push is the first output.

Source files
------------

// File: rtl/limber_gnrl_ramfifo_ctrl.sv
// FIFO controller for an external RAM with DLY-cycle read latency.
// Read-ahead is limited by credits so the small output queue cannot overflow.
module limber_gnrl_ramfifo_ctrl #(
    parameter int DP  = 4,
    parameter int AW  = 2,
    parameter int DW  = 3,
    parameter int DLY = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_vld,
    output logic          i_rdy,
    input  logic [DW-1:0] i_dat,
    output logic          o_vld,
    input  logic          o_rdy,
    output logic [DW-1:0] o_dat,
    output logic          ram_cs,
    output logic          ram_we,
    output logic [AW-1:0] ram_waddr,
    output logic [AW-1:0] ram_raddr,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout,
    output logic [AW:0]   usedw
);

    localparam int QD  = DLY + 1;
    localparam int QPW = $clog2(QD);
    localparam int OW  = $clog2(QD + 1);

    logic [AW-1:0]  r_wptr;
    logic [AW-1:0]  r_rptr;
    logic [AW:0]    r_usedw;
    logic [DLY-1:0] r_pipe;
    logic [OW-1:0]  r_outst;
    logic [DW-1:0]  r_q [QD];
    logic [QPW-1:0] r_qwp;
    logic [QPW-1:0] r_qrp;
    logic [OW-1:0]  r_qcnt;

    logic w_push;
    logic w_pop;
    logic w_issue;
    logic w_cap;

    function automatic logic [QPW-1:0] qnext(input logic [QPW-1:0] p);
        return (p == QPW'(DLY)) ? '0 : p + 1'b1;
    endfunction

    assign i_rdy  = (r_usedw < (AW+1)'(DP));
    assign w_push = rst_n & i_vld & i_rdy;
    assign o_vld  = (r_qcnt != '0);
    assign o_dat  = r_q[r_qrp];
    assign w_pop  = o_vld & o_rdy;
    // A pop this cycle frees a queue slot, so it returns a credit immediately;
    // without this a streaming FIFO would only deliver every other cycle.
    assign w_issue = (r_usedw != '0) & ((r_outst != OW'(QD)) | w_pop);
    assign w_cap   = r_pipe[DLY-1];

    assign ram_we    = w_push;
    assign ram_cs    = w_push | w_issue;
    assign ram_waddr = r_wptr;
    assign ram_raddr = r_rptr;
    assign ram_din   = i_dat;
    assign usedw     = r_usedw;

    // Pointers wrap naturally because DP is a power of two; full/empty come from usedw.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_usedw <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_issue) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (w_push && !w_issue) begin
                r_usedw <= r_usedw + 1'b1;
            end else if (!w_push && w_issue) begin
                r_usedw <= r_usedw - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pipe  <= '0;
            r_outst <= '0;
        end else begin
            r_pipe[0] <= w_issue;
            for (int k = 1; k < DLY; k++) begin
                r_pipe[k] <= r_pipe[k-1];
            end
            if (w_issue && !w_pop) begin
                r_outst <= r_outst + 1'b1;
            end else if (!w_issue && w_pop) begin
                r_outst <= r_outst - 1'b1;
            end
        end
    end

    // Capture and pop may coincide even when full; credits guarantee a free slot otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < QD; k++) begin
                r_q[k] <= '0;
            end
            r_qwp  <= '0;
            r_qrp  <= '0;
            r_qcnt <= '0;
        end else begin
            if (w_cap) begin
                r_q[r_qwp] <= ram_dout;
                r_qwp      <= qnext(r_qwp);
            end
            if (w_pop) begin
                r_qrp <= qnext(r_qrp);
            end
            if (w_cap && !w_pop) begin
                r_qcnt <= r_qcnt + 1'b1;
            end else if (!w_cap && w_pop) begin
                r_qcnt <= r_qcnt - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_limber_gnrl_ramfifo_ctrl.sv
// Bench for limber_gnrl_ramfifo_ctrl: RAM model, occupancy/scoreboard model with
// a per-cycle compare process, and directed scenarios with literal expectations.
module tb_limber_gnrl_ramfifo_ctrl;

    localparam int DP  = 4;
    localparam int AW  = 2;
    localparam int DW  = 8;
    localparam int DLY = 1;

    logic          clk;
    logic          rst_n;
    logic          i_vld;
    logic          i_rdy;
    logic [DW-1:0] i_dat;
    logic          o_vld;
    logic          o_rdy;
    logic [DW-1:0] o_dat;
    logic          ram_cs;
    logic          ram_we;
    logic [AW-1:0] ram_waddr;
    logic [AW-1:0] ram_raddr;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;
    logic [AW:0]   usedw;

    int errCount   = 0;
    int checkCount = 0;

    limber_gnrl_ramfifo_ctrl #(.DP(DP), .AW(AW), .DW(DW), .DLY(DLY)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_vld    (i_vld),
        .i_rdy    (i_rdy),
        .i_dat    (i_dat),
        .o_vld    (o_vld),
        .o_rdy    (o_rdy),
        .o_dat    (o_dat),
        .ram_cs   (ram_cs),
        .ram_we   (ram_we),
        .ram_waddr(ram_waddr),
        .ram_raddr(ram_raddr),
        .ram_din  (ram_din),
        .ram_dout (ram_dout),
        .usedw    (usedw)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Simple two-port RAM with a one-clock registered read.
    logic [DW-1:0] mem [DP];
    always @(posedge clk) begin
        if (ram_cs && ram_we) mem[ram_waddr] <= ram_din;
        if (ram_cs) ram_dout <= mem[ram_raddr];
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act !== exp) begin
            errCount++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model: every accepted word waits in order in sb; occupancy is split into
    // words held in RAM (mUsed), reads in flight and words in the output queue.
    logic [DW-1:0] sb [$];
    int            flight [$];
    int            mUsed = 0;
    int            mQ    = 0;
    int            mW    = 0;
    int            mR    = 0;
    int            caps;
    bit            ePush, ePop, eIssue;
    logic [DW-1:0] pushData;

    always begin
        @(negedge clk);
        if (!rst_n) begin
            checkOutput("rst_i_rdy", i_rdy, 1);
            checkOutput("rst_o_vld", o_vld, 0);
            checkOutput("rst_ram_cs", ram_cs, 0);
            checkOutput("rst_ram_we", ram_we, 0);
            checkOutput("rst_usedw", usedw, 0);
            checkOutput("rst_raddr", ram_raddr, 0);
            checkOutput("rst_waddr", ram_waddr, 0);
            sb.delete();
            flight.delete();
            mUsed = 0; mQ = 0; mW = 0; mR = 0;
            ePush = 0; ePop = 0; eIssue = 0;
        end else begin
            ePush    = i_vld && (mUsed < DP);
            ePop     = (mQ > 0) && o_rdy;
            eIssue   = (mUsed > 0) && ((flight.size() + mQ - int'(ePop)) < DLY + 1);
            pushData = i_dat;
            checkOutput("m_i_rdy", i_rdy, mUsed < DP);
            checkOutput("m_usedw", usedw, 32'(mUsed));
            checkOutput("m_o_vld", o_vld, mQ > 0);
            if (mQ > 0) checkOutput("m_o_dat", o_dat, sb[0]);
            checkOutput("m_ram_we", ram_we, ePush);
            checkOutput("m_ram_cs", ram_cs, ePush || eIssue);
            checkOutput("m_raddr", ram_raddr, 32'(mR));
            if (ePush) begin
                checkOutput("m_waddr", ram_waddr, 32'(mW));
                checkOutput("m_din", ram_din, i_dat);
            end
        end
        @(posedge clk);
        if (rst_n) begin
            caps = 0;
            while (flight.size() > 0 && flight[0] == 1) begin
                void'(flight.pop_front());
                caps++;
            end
            foreach (flight[i]) flight[i]--;
            mQ += caps;
            if (ePop) begin
                void'(sb.pop_front());
                mQ--;
            end
            if (ePush) begin
                sb.push_back(pushData);
                mW = (mW + 1) % DP;
                mUsed++;
            end
            if (eIssue) begin
                mUsed--;
                mR = (mR + 1) % DP;
                flight.push_back(DLY);
            end
        end
    end

    initial begin
        #100000;
        errCount++;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $fatal(1, "[TB] timeout");
    end

    logic [DW-1:0] got [32];
    int  n, firstIdx, lastIdx;
    bit  pushNow, held, found;
    logic [DW-1:0] heldVal;
    int  nextK;

    initial begin
        rst_n = 1'b0; i_vld = 1'b0; i_dat = '0; o_rdy = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // Single entry: push 0xA5, read issued next cycle, visible after two edges.
        i_vld = 1'b1; i_dat = 8'hA5; o_rdy = 1'b1;
        tick();
        i_vld = 1'b0;
        @(negedge clk);
        checkOutput("single_usedw1", usedw, 1);
        checkOutput("single_issue_cs", ram_cs, 1);
        checkOutput("single_raddr", ram_raddr, 0);
        checkOutput("single_vld_early", o_vld, 0);
        tick();
        @(negedge clk);
        checkOutput("single_vld_e1", o_vld, 0);
        checkOutput("single_usedw0", usedw, 0);
        tick();
        @(negedge clk);
        checkOutput("single_vld_e2", o_vld, 1);
        checkOutput("single_dat", o_dat, 8'hA5);
        tick();
        @(negedge clk);
        checkOutput("single_vld_after", o_vld, 0);
        tick();

        // Fill to full with the reader stalled.
        o_rdy = 1'b0;
        for (int v = 1; v <= 6; v++) begin
            i_vld = 1'b1; i_dat = 8'(v);
            checkOutput("fill_i_rdy", i_rdy, 1);
            tick();
        end
        i_dat = 8'h07;
        @(negedge clk);
        checkOutput("full_usedw", usedw, 4);
        checkOutput("full_i_rdy", i_rdy, 0);
        checkOutput("full_o_vld", o_vld, 1);
        checkOutput("full_o_dat", o_dat, 8'h01);
        repeat (3) tick();
        @(negedge clk);
        checkOutput("stall_i_rdy", i_rdy, 0);
        checkOutput("stall_o_dat", o_dat, 8'h01);
        tick();

        // Drain with the stalled 7th/8th words entering as space frees.
        o_rdy = 1'b1;
        n = 0;
        for (int cyc = 0; cyc < 40 && n < 8; cyc++) begin
            @(negedge clk);
            if (o_vld && o_rdy) begin got[n] = o_dat; n++; end
            pushNow = i_vld && i_rdy;
            tick();
            if (pushNow) begin
                if (i_dat == 8'h07) i_dat = 8'h08;
                else i_vld = 1'b0;
            end
        end
        checkOutput("drain_count", n, 8);
        for (int i = 0; i < n; i++) checkOutput("drain_order", got[i], 8'(i + 1));
        i_vld = 1'b0;
        repeat (3) tick();

        // Streaming: one word per clock after a two-clock fill.
        o_rdy = 1'b1; n = 0; firstIdx = -1; lastIdx = -1;
        for (int k = 0; k < 26; k++) begin
            if (k < 20) begin i_vld = 1'b1; i_dat = 8'(8'h10 + k); end
            else i_vld = 1'b0;
            @(negedge clk);
            if (k < 20) checkOutput("stream_i_rdy", i_rdy, 1);
            checkOutput("stream_usedw_le1", usedw <= 1, 1);
            if (o_vld) begin
                if (firstIdx < 0) firstIdx = k;
                lastIdx = k;
                checkOutput("stream_dat", o_dat, 8'(8'h10 + n));
                n++;
            end
            tick();
        end
        checkOutput("stream_first", firstIdx, 3);
        checkOutput("stream_count", n, 20);
        checkOutput("stream_nogap", lastIdx - firstIdx + 1, 20);
        repeat (2) tick();

        // Backpressure: reader toggles every cycle, writer pushes continuously.
        o_rdy = 1'b1; i_vld = 1'b1; nextK = 0; i_dat = 8'h40; n = 0; held = 1'b0; heldVal = '0;
        for (int cyc = 0; cyc < 80 && n < 16; cyc++) begin
            @(negedge clk);
            if (held) begin
                checkOutput("bp_hold_vld", o_vld, 1);
                checkOutput("bp_hold_dat", o_dat, heldVal);
            end
            if (o_vld && o_rdy) begin got[n] = o_dat; n++; end
            held    = o_vld && !o_rdy;
            heldVal = o_dat;
            pushNow = i_vld && i_rdy;
            tick();
            if (pushNow) begin
                nextK++;
                if (nextK < 16) i_dat = 8'(8'h40 + nextK);
                else i_vld = 1'b0;
            end
            o_rdy = ~o_rdy;
        end
        checkOutput("bp_count", n, 16);
        for (int i = 0; i < n; i++) checkOutput("bp_order", got[i], 8'(8'h40 + i));
        i_vld = 1'b0; o_rdy = 1'b1;
        repeat (3) tick();

        // Reset mid-stream with data in RAM and in the output queue.
        o_rdy = 1'b0;
        for (int v = 0; v < 5; v++) begin
            i_vld = 1'b1; i_dat = 8'(8'h51 + v);
            tick();
        end
        i_vld = 1'b0;
        @(negedge clk);
        checkOutput("pre_rst_usedw", usedw, 3);
        checkOutput("pre_rst_o_vld", o_vld, 1);
        tick();
        rst_n = 1'b0; i_vld = 1'b1; i_dat = 8'h77; o_rdy = 1'b1;
        #1;
        checkOutput("rst_now_o_vld", o_vld, 0);
        checkOutput("rst_now_usedw", usedw, 0);
        checkOutput("rst_now_i_rdy", i_rdy, 1);
        checkOutput("rst_now_ram_we", ram_we, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        i_vld = 1'b0;
        found = 1'b0; firstIdx = -1; heldVal = '0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (o_vld) begin found = 1'b1; firstIdx = i; heldVal = o_dat; end
            else tick();
        end
        checkOutput("post_rst_found", found, 1);
        checkOutput("post_rst_latency", firstIdx, 2);
        checkOutput("post_rst_dat", heldVal, 8'h77);
        tick();
        @(negedge clk);
        checkOutput("post_rst_empty", o_vld, 0);
        repeat (2) tick();

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
